// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipelined MIPS control: ID decode, ID/EX..MEM/WB control bundle, hazards, MDU busy counter.
// Optional multiply/divide support is compiled in when CTRL_MDU_EN is defined.
module pipe_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W = $clog2(MDU_LATENCY + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic       zero,
  output logic       id_stall,
  output logic       if_flush,
  output logic [1:0] s_npc,
  output logic [3:0] ex_aluop,
  output logic       ex_s_a,
  output logic       ex_s_b,
  output logic       ex_s_ext,
  output logic       ex_mdu_start,
  output logic       mem_write,
  output logic       wb_reg_write,
  output logic [1:0] wb_s_data_write,
  output logic [4:0] wb_num_write,
  output logic       mdu_busy
);

  localparam logic [3:0] ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3, ALU_OR = 4'd4,
                         ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_LUI = 4'd7;

  if (MDU_LATENCY < 1 || CNT_W < 1) begin : g_cfg_check
    $error("pipe_ctrl: MDU_LATENCY must be at least 1");
  end

  logic [3:0] dec_aluop;
  logic       dec_s_a, dec_s_b, dec_s_ext, dec_mw, dec_wr;
  logic [1:0] dec_sd, dec_npc;
  logic [4:0] dec_num;
  logic       use_rs, use_rt, is_br;
  logic       load_use, br_haz, mdu_haz, stall;

  logic [3:0] ex_aluop_q, ex_aluop_d;
  logic       ex_s_a_q, ex_s_a_d, ex_s_b_q, ex_s_b_d, ex_s_ext_q, ex_s_ext_d;
  logic       ex_mw_q, ex_mw_d, ex_rw_q, ex_rw_d;
  logic [1:0] ex_sd_q, ex_sd_d;
  logic [4:0] ex_num_q, ex_num_d;
  logic       mem_mw_q, mem_mw_d, mem_rw_q, mem_rw_d;
  logic [1:0] mem_sd_q, mem_sd_d;
  logic [4:0] mem_num_q, mem_num_d;
  logic       wb_rw_q, wb_rw_d;
  logic [1:0] wb_sd_q, wb_sd_d;
  logic [4:0] wb_num_q, wb_num_d;

`ifdef CTRL_MDU_EN
  localparam logic [3:0] ALU_MFHI = 4'd8, ALU_MFLO = 4'd9;
  logic             dec_mdu, is_mf;
  logic             ex_mdu_q, ex_mdu_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    dec_aluop = 4'd0;
    dec_s_a   = 1'b0;
    dec_s_b   = 1'b0;
    dec_s_ext = 1'b0;
    dec_mw    = 1'b0;
    dec_wr    = 1'b0;
    dec_sd    = 2'd0;
    dec_npc   = 2'd0;
    dec_num   = 5'd0;
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    is_br     = 1'b0;
`ifdef CTRL_MDU_EN
    dec_mdu   = 1'b0;
    is_mf     = 1'b0;
`endif
    case (op)
      6'h00: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        dec_num = rd;
        case (funct)
          6'h20, 6'h21: begin dec_aluop = ALU_ADD; dec_wr = 1'b1; end
          6'h23:        begin dec_aluop = ALU_SUB; dec_wr = 1'b1; end
          6'h24:        begin dec_aluop = ALU_AND; dec_wr = 1'b1; end
          6'h25:        begin dec_aluop = ALU_OR;  dec_wr = 1'b1; end
          6'h2A:        begin dec_aluop = ALU_SLT; dec_wr = 1'b1; end
          6'h00:        begin dec_aluop = ALU_SLL; dec_wr = 1'b1; use_rs = 1'b0; end
          6'h08:        begin dec_npc = 2'd2; is_br = 1'b1; end
`ifdef CTRL_MDU_EN
          6'h18, 6'h19, 6'h1A, 6'h1B: dec_mdu = 1'b1;
          6'h10:        begin dec_aluop = ALU_MFHI; dec_wr = 1'b1; is_mf = 1'b1; end
          6'h12:        begin dec_aluop = ALU_MFLO; dec_wr = 1'b1; is_mf = 1'b1; end
`endif
          default:      begin use_rs = 1'b0; use_rt = 1'b0; end
        endcase
      end
      6'h02: dec_npc = 2'd1;
      6'h03: begin
        dec_aluop = ALU_ADD; dec_s_a = 1'b1; dec_wr = 1'b1;
        dec_num = 5'd31; dec_sd = 2'd2; dec_npc = 2'd1;
      end
      6'h04: begin
        dec_aluop = ALU_SUB; dec_s_ext = 1'b1; use_rs = 1'b1; use_rt = 1'b1; is_br = 1'b1;
        dec_npc = zero ? 2'd3 : 2'd0;
      end
      6'h08, 6'h09: begin
        dec_aluop = ALU_ADD; dec_s_b = 1'b1; dec_s_ext = 1'b1; dec_wr = 1'b1;
        dec_num = rt; use_rs = 1'b1;
      end
      6'h0C: begin dec_aluop = ALU_AND; dec_s_b = 1'b1; dec_wr = 1'b1; dec_num = rt; use_rs = 1'b1; end
      6'h0D: begin dec_aluop = ALU_OR;  dec_s_b = 1'b1; dec_wr = 1'b1; dec_num = rt; use_rs = 1'b1; end
      6'h0F: begin dec_aluop = ALU_LUI; dec_s_b = 1'b1; dec_wr = 1'b1; dec_num = rt; end
      6'h23: begin
        dec_aluop = ALU_ADD; dec_s_b = 1'b1; dec_s_ext = 1'b1; dec_wr = 1'b1;
        dec_sd = 2'd1; dec_num = rt; use_rs = 1'b1;
      end
      6'h2B: begin
        dec_aluop = ALU_ADD; dec_s_b = 1'b1; dec_s_ext = 1'b1; dec_mw = 1'b1;
        use_rs = 1'b1; use_rt = 1'b1;
      end
      default: ;
    endcase
    // Writes to $0 are dropped; non-writing slots carry register number 0.
    if (dec_num == 5'd0) dec_wr = 1'b0;
    if (!dec_wr) dec_num = 5'd0;
  end

  always_comb begin
    load_use = (ex_sd_q == 2'd1) &&
               ((use_rs && rs != 5'd0 && rs == ex_num_q) ||
                (use_rt && rt != 5'd0 && rt == ex_num_q));
    br_haz   = is_br &&
               ((use_rs && ((ex_rw_q && rs == ex_num_q) || (mem_sd_q == 2'd1 && rs == mem_num_q))) ||
                (use_rt && ((ex_rw_q && rt == ex_num_q) || (mem_sd_q == 2'd1 && rt == mem_num_q))));
`ifdef CTRL_MDU_EN
    mdu_haz  = (dec_mdu || is_mf) && (cnt_q != '0);
`else
    mdu_haz  = 1'b0;
`endif
    stall    = ~rst & (load_use | br_haz | mdu_haz);
  end

  assign id_stall = stall;
  assign s_npc    = (stall || rst) ? 2'd0 : dec_npc;
  assign if_flush = (s_npc != 2'd0);

  always_comb begin
    ex_aluop_d = stall ? 4'd0 : dec_aluop;
    ex_s_a_d   = ~stall & dec_s_a;
    ex_s_b_d   = ~stall & dec_s_b;
    ex_s_ext_d = ~stall & dec_s_ext;
    ex_mw_d    = ~stall & dec_mw;
    ex_rw_d    = ~stall & dec_wr;
    ex_sd_d    = stall ? 2'd0 : dec_sd;
    ex_num_d   = stall ? 5'd0 : dec_num;
    mem_mw_d   = ex_mw_q;
    mem_rw_d   = ex_rw_q;
    mem_sd_d   = ex_sd_q;
    mem_num_d  = ex_num_q;
    wb_rw_d    = mem_rw_q;
    wb_sd_d    = mem_sd_q;
    wb_num_d   = mem_num_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_aluop_q <= 4'd0;
      ex_s_a_q   <= 1'b0;
      ex_s_b_q   <= 1'b0;
      ex_s_ext_q <= 1'b0;
      ex_mw_q    <= 1'b0;
      ex_rw_q    <= 1'b0;
      ex_sd_q    <= 2'd0;
      ex_num_q   <= 5'd0;
      mem_mw_q   <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_sd_q   <= 2'd0;
      mem_num_q  <= 5'd0;
      wb_rw_q    <= 1'b0;
      wb_sd_q    <= 2'd0;
      wb_num_q   <= 5'd0;
    end else begin
      ex_aluop_q <= ex_aluop_d;
      ex_s_a_q   <= ex_s_a_d;
      ex_s_b_q   <= ex_s_b_d;
      ex_s_ext_q <= ex_s_ext_d;
      ex_mw_q    <= ex_mw_d;
      ex_rw_q    <= ex_rw_d;
      ex_sd_q    <= ex_sd_d;
      ex_num_q   <= ex_num_d;
      mem_mw_q   <= mem_mw_d;
      mem_rw_q   <= mem_rw_d;
      mem_sd_q   <= mem_sd_d;
      mem_num_q  <= mem_num_d;
      wb_rw_q    <= wb_rw_d;
      wb_sd_q    <= wb_sd_d;
      wb_num_q   <= wb_num_d;
    end
  end

`ifdef CTRL_MDU_EN
  always_comb begin
    ex_mdu_d = ~stall & dec_mdu;
    cnt_d    = cnt_q;
    if (dec_mdu && !stall) cnt_d = CNT_W'(MDU_LATENCY);
    else if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mdu_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ex_mdu_q <= ex_mdu_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_mdu_start = ex_mdu_q;
  assign mdu_busy     = (cnt_q != '0);
`else
  assign ex_mdu_start = 1'b0;
  assign mdu_busy     = 1'b0;
`endif

  assign ex_aluop        = ex_aluop_q;
  assign ex_s_a          = ex_s_a_q;
  assign ex_s_b          = ex_s_b_q;
  assign ex_s_ext        = ex_s_ext_q;
  assign mem_write       = mem_mw_q;
  assign wb_reg_write    = wb_rw_q;
  assign wb_s_data_write = wb_sd_q;
  assign wb_num_write    = wb_num_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control unit for the five-stage MIPS core; successor to the single-stage combinational decoder. Decodes op/funct in ID, carries the control bundle through ID/EX, EX/MEM and MEM/WB registers, and resolves the write-register number in ID. Also detects load-use and branch-operand hazards, and owns a multi-cycle multiply/divide (MDU) busy counter. Drives IF/ID stall, flush and next-PC select.

## Interface
- MDU_LATENCY, 32, cycles an MDU operation occupies the unit (≥1)
- CNT_W, $clog2(MDU_LATENCY+1), busy-counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  ID instruction opcode
- funct  in  6  ID instruction funct
- rs, rt, rd  in  5 each  ID register fields
- zero  in  1  ID branch comparator result (rs == rt)
- id_stall  out  1  hold PC and IF/ID; inject bubble into ID/EX
- if_flush  out  1  squash IF/ID contents
- s_npc  out  2  0 sequential, 1 J, 2 JR, 3 BEQ taken
- ex_aluop  out  4  ALU opcode (def.v encodings)
- ex_s_a, ex_s_b  out  1 each  ALU A select (0 reg, 1 nPC); ALU B select (0 reg, 1 imm)
- ex_s_ext  out  1  0 zero-extend, 1 sign-extend
- ex_mdu_start  out  1  MDU op in EX
- mem_write  out  1  data-memory write enable in MEM
- wb_reg_write  out  1  register-file write enable in WB
- wb_s_data_write  out  2  0 ALU, 1 MEM, 2 nPC
- wb_num_write  out  5  destination register in WB
- mdu_busy  out  1  MDU counter nonzero

## Operation
- Decode set: ADD/ADDU/SUBU/AND/OR/SLT/SLL/JR, ADDI/ADDIU/ANDI/ORI/LUI/LW/SW/J/JAL/BEQ. MULT/MULTU/DIV/DIVU (funct 0x18–0x1B) and MFHI/MFLO (0x10/0x12) are decoded only under the macro. Any other encoding is a bubble: all enables 0, s_npc 0.
- Destination resolved in ID: rd for R-type, rt for I-type including LUI, 31 for JAL. A destination of 0 forces reg_write to 0.
- Operand use: rs is used by every instruction except J/JAL/LUI/SLL. rt is used by R-type, BEQ and SW.
- Load-use hazard: EX holds LW and its dest equals a used, nonzero ID source. Result: stall.
- Branch hazard: ID holds BEQ/JR and a used source equals EX dest (EX reg_write=1), or equals MEM dest (MEM is LW). Result: stall.
- MDU hazard: ID holds MFHI/MFLO or an MDU op while mdu_busy=1. Result: stall.
- Stall: id_stall=1, if_flush=0, s_npc forced to 0, ID/EX loads a bubble. EX/MEM/WB continue advancing.
- No stall: s_npc from decode; BEQ selects 3 only when zero=1. if_flush=1 whenever s_npc≠0.
- MDU counter: an MDU op leaving ID unstalled loads MDU_LATENCY. Otherwise the counter decrements while nonzero. It saturates at 0.

## Timing
- Reset: every pipeline register cleared to a bubble and the counter cleared to 0. All outputs read 0 while rst=1 and until the first instruction reaches that stage.
- Instruction decoded in ID in cycle N appears on ex_* in N+1, mem_write in N+2, wb_* in N+3.
- id_stall, if_flush and s_npc are combinational from the ID inputs and the EX/MEM register state.
- MDU op in ID at cycle N: ex_mdu_start=1 in N+1; mdu_busy=1 for cycles N+1 … N+MDU_LATENCY.
- Simultaneous hazard and taken branch/jump: the stall wins and the branch is re-evaluated next cycle.
- Reset asserted mid-operation: the pipeline is cleared immediately and any in-flight MDU count is discarded.

## Configuration
- CTRL_MDU_EN defined: MDU/MFHI/MFLO decode, busy counter, MDU hazard, ex_mdu_start and mdu_busy are compiled in.
- CTRL_MDU_EN undefined: those functs decode as bubbles; ex_mdu_start and mdu_busy are tied to 0; no counter logic is built.

## Test plan
- Reset: hold rst=1 with ORI in ID → every output 0. Release → ORI dest rt reaches wb_num_write 3 cycles later with wb_reg_write=1 and wb_s_data_write=0.
- Load-use: LW $2 in ID at cycle N, then ADDU $3,$2,$4 in ID at N+1 → id_stall=1 for exactly one cycle; the ADDU reaches EX at N+3.
- BEQ after ADDU writing $5, with BEQ reading $5 → one stall cycle. Then with zero=1 → s_npc=3 and if_flush=1. With zero=0 → s_npc=0 and if_flush=0.
- JAL → s_npc=1, if_flush=1; three cycles later wb_num_write=31 and wb_s_data_write=2.
- With CTRL_MDU_EN and MDU_LATENCY=4: MULT followed by MFLO → mdu_busy high for 4 cycles and MFLO stalled until mdu_busy drops.
- Without CTRL_MDU_EN: the same sequence produces no stall, and mdu_busy stays 0.
